// File: rtl/argmax_layer.sv
// -----------------------------------------------------------------------------
// argmax_layer
//
// Output decoder for the dense-layer datapath. For each of N sequence
// positions it picks the index of the largest of CHAR_NUM signed scores.
// One character column is examined per clock, with all N positions compared
// in parallel, so a result takes CHAR_NUM-1 cycles after run is accepted.
//
// Ports:
//   clk      rising-edge system clock
//   rst      synchronous, active-high reset
//   run      level-sensitive start request (must drop before a re-run)
//   d        packed scores, element (p,c) at d[(p*CHAR_NUM+c)*N_LEN +: N_LEN];
//            must be held stable from the run sample until valid rises
//   valid    high while the result is presented (DONE state)
//   q        argmax index of position p at q[p*IDX_W +: IDX_W]
//   q_score  (only with ARGMAX_SCORE_OUT_EN) max score of position p at
//            q_score[p*N_LEN +: N_LEN], registered together with q
//
// Optional feature macro: ARGMAX_SCORE_OUT_EN
// -----------------------------------------------------------------------------
module argmax_layer #(
    parameter int N        = 10,
    parameter int CHAR_NUM = 200,
    parameter int N_LEN    = 16,
    parameter int IDX_W    = $clog2(CHAR_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [N*CHAR_NUM*N_LEN-1:0]  d,
    output logic                         valid,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic [N*N_LEN-1:0]           q_score,
`endif
    output logic [N*IDX_W-1:0]           q
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAR_NUM - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        cnt;
    logic                    last;

    logic signed [N_LEN-1:0] best_val [N];
    logic [IDX_W-1:0]        best_idx [N];
    logic signed [N_LEN-1:0] cand_val [N];
    logic signed [N_LEN-1:0] upd_val  [N];
    logic [IDX_W-1:0]        upd_idx  [N];

    // Strict greater-than: on equal scores the earlier (lower) index is kept.
    function automatic logic beats(input logic signed [N_LEN-1:0] a,
                                   input logic signed [N_LEN-1:0] b);
        return a > b;
    endfunction

    assign last  = (cnt == LAST_IDX);
    assign valid = (state == DONE);

    // Column cnt of every position, and the running best after comparing it.
    always_comb begin
        for (int p = 0; p < N; p++) begin
            cand_val[p] = d[(p*CHAR_NUM + int'(cnt))*N_LEN +: N_LEN];
            upd_val[p]  = best_val[p];
            upd_idx[p]  = best_idx[p];
            if (beats(cand_val[p], best_val[p])) begin
                upd_val[p] = cand_val[p];
                upd_idx[p] = cnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run)  state_nxt = SCAN;
            SCAN:    if (last) state_nxt = DONE;
            DONE:    if (!run) state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
            q_score <= '0;
`endif
            for (int p = 0; p < N; p++) begin
                best_val[p] <= '0;
                best_idx[p] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Column 0 seeds the search so the scan starts at cnt=1.
                    if (run) begin
                        cnt <= IDX_W'(1);
                        for (int p = 0; p < N; p++) begin
                            best_val[p] <= d[p*CHAR_NUM*N_LEN +: N_LEN];
                            best_idx[p] <= '0;
                        end
                    end
                end
                SCAN: begin
                    cnt <= cnt + 1'b1;
                    for (int p = 0; p < N; p++) begin
                        best_val[p] <= upd_val[p];
                        best_idx[p] <= upd_idx[p];
                    end
                    // Final column: publish including this edge's update.
                    if (last) begin
                        for (int p = 0; p < N; p++) begin
                            q[p*IDX_W +: IDX_W] <= upd_idx[p];
`ifdef ARGMAX_SCORE_OUT_EN
                            q_score[p*N_LEN +: N_LEN] <= upd_val[p];
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_layer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for argmax_layer at default parameters.
// -----------------------------------------------------------------------------
module tb_argmax_layer;

    localparam int N        = 10;
    localparam int CHAR_NUM = 200;
    localparam int N_LEN    = 16;
    localparam int IDX_W    = 8;
    localparam int LAT      = 199;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        run = 1'b0;
    logic [N*CHAR_NUM*N_LEN-1:0] d   = '0;
    logic                        valid;
    logic [N*IDX_W-1:0]          q;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [N*N_LEN-1:0]          q_score;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed (17*p+3) % 200 for p = 0..9.
    int basic_idx [N] = '{3, 20, 37, 54, 71, 88, 105, 122, 139, 156};
    logic [N*IDX_W-1:0] basic_q;

    argmax_layer #(
        .N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .d(d),
        .valid(valid),
`ifdef ARGMAX_SCORE_OUT_EN
        .q_score(q_score),
`endif
        .q(q)
    );

    always #5 clk = ~clk;

    task automatic set_elem(input int p, input int c, input int v);
        d[(p*CHAR_NUM + c)*N_LEN +: N_LEN] = N_LEN'(v);
    endtask

    task automatic load_basic();
        for (int p = 0; p < N; p++)
            for (int c = 0; c < CHAR_NUM; c++)
                set_elem(p, c, (c == basic_idx[p]) ? 1000 : c - 100);
    endtask

    // Raise run, let it be sampled, optionally drop it, and count edges until
    // valid (bounded). lat = -1 if valid never rose.
    task automatic run_scan(input bit pulse, output int lat);
        run = 1'b1;
        @(posedge clk); #1;
        if (pulse) run = 1'b0;
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", valid);
        end
        checks++;
        if (q !== '0) begin
            errors++; $display("FAIL reset_q: got %h expected 0", q);
        end
`ifdef ARGMAX_SCORE_OUT_EN
        checks++;
        if (q_score !== '0) begin
            errors++; $display("FAIL reset_q_score: got %h expected 0", q_score);
        end
`endif
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL idle_valid: valid high %0d cycles, expected 0", seen);
        end
    endtask

    task automatic test_basic();
        int lat;
        int held;
        load_basic();
        run_scan(1'b0, lat);
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
        end
        for (int p = 0; p < N; p++) begin
            checks++;
            if (q[p*IDX_W +: IDX_W] !== IDX_W'(basic_idx[p])) begin
                errors++;
                $display("FAIL basic_q[%0d]: got %0d expected %0d", p, q[p*IDX_W +: IDX_W], basic_idx[p]);
            end
`ifdef ARGMAX_SCORE_OUT_EN
            checks++;
            if (q_score[p*N_LEN +: N_LEN] !== 16'sd1000) begin
                errors++;
                $display("FAIL basic_q_score[%0d]: got %0d expected 1000", p, $signed(q_score[p*N_LEN +: N_LEN]));
            end
`endif
        end
        held = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid === 1'b1) held++;
        end
        checks++;
        if (held != 5) begin
            errors++; $display("FAIL basic_hold: valid high %0d of 5 cycles", held);
        end
    endtask

    // Re-arm into the ties/extremes pattern.
    task automatic test_rearm_ties();
        int lat;
        int held;
        for (int p = 0; p < N; p++)
            for (int c = 0; c < CHAR_NUM; c++)
                case (p)
                    0: set_elem(p, c, 32767);
                    1: set_elem(p, c, (c == 199) ? -32767 : -32768);
                    2: set_elem(p, c, (c == 5 || c == 150) ? 500 : c - 100);
                    default: set_elem(p, c, c - 100);
                endcase
        held = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (valid === 1'b1) held++;
        end
        checks++;
        if (held != 50) begin
            errors++; $display("FAIL rearm_hold_valid: valid high %0d of 50 cycles", held);
        end
        checks++;
        if (q !== basic_q) begin
            errors++; $display("FAIL rearm_hold_q: got %h expected %h", q, basic_q);
        end
        run = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL rearm_drop: valid got %b expected 0", valid);
        end
        run_scan(1'b0, lat);
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL rearm_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (q[0*IDX_W +: IDX_W] !== 8'd0) begin
            errors++; $display("FAIL tie_all_equal q[0]: got %0d expected 0", q[0*IDX_W +: IDX_W]);
        end
        checks++;
        if (q[1*IDX_W +: IDX_W] !== 8'd199) begin
            errors++; $display("FAIL most_negative q[1]: got %0d expected 199", q[1*IDX_W +: IDX_W]);
        end
        checks++;
        if (q[2*IDX_W +: IDX_W] !== 8'd5) begin
            errors++; $display("FAIL tie_duplicate q[2]: got %0d expected 5", q[2*IDX_W +: IDX_W]);
        end
        checks++;
        if (q[3*IDX_W +: IDX_W] !== 8'd199) begin
            errors++; $display("FAIL last_column q[3]: got %0d expected 199", q[3*IDX_W +: IDX_W]);
        end
`ifdef ARGMAX_SCORE_OUT_EN
        checks++;
        if (q_score[1*N_LEN +: N_LEN] !== 16'h8001) begin
            errors++; $display("FAIL most_negative q_score[1]: got %h expected 8001", q_score[1*N_LEN +: N_LEN]);
        end
`endif
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    // Single-cycle run: scores descending so every position picks index 0
    // except position 4, whose max sits at column 77.
    task automatic test_run_pulse();
        int lat;
        for (int p = 0; p < N; p++)
            for (int c = 0; c < CHAR_NUM; c++)
                set_elem(p, c, (p == 4 && c == 77) ? 2000 : 100 - c);
        run_scan(1'b1, lat);
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL pulse_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (q[0*IDX_W +: IDX_W] !== 8'd0 || q[4*IDX_W +: IDX_W] !== 8'd77) begin
            errors++;
            $display("FAIL pulse_q: got q[0]=%0d q[4]=%0d expected 0 and 77", q[0*IDX_W +: IDX_W], q[4*IDX_W +: IDX_W]);
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL pulse_one_cycle: valid got %b expected 0", valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        int lat;
        load_basic();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || q !== '0) begin
            errors++; $display("FAIL mid_scan_reset: valid=%b q=%h expected 0 and 0", valid, q);
        end
        seen = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_scan_no_valid: valid high %0d cycles, expected 0", seen);
        end
        // run and rst together: reset must win and no scan may start.
        run = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        seen = 0;
        repeat (250) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL run_with_reset: valid high %0d cycles, expected 0", seen);
        end
        run_scan(1'b0, lat);
        checks++;
        if (lat != LAT || q !== basic_q) begin
            errors++; $display("FAIL post_reset_scan: latency %0d q %h expected %0d and %h", lat, q, LAT, basic_q);
        end
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int p = 0; p < N; p++) basic_q[p*IDX_W +: IDX_W] = IDX_W'(basic_idx[p]);
        test_reset();
        test_basic();
        test_rearm_ties();
        test_run_pulse();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
